// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU operation codes, RV32I opcodes,
// operand/immediate selectors, the registered issue packet and an immediate helper.
package alu_pkg;

  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_XOR    = 4'b0010;
  localparam logic [3:0] ALU_ADD    = 4'b0011;
  localparam logic [3:0] ALU_SUB    = 4'b0100;
  localparam logic [3:0] ALU_PASS_B = 4'b0110;
  localparam logic [3:0] ALU_SLL    = 4'b0111;
  localparam logic [3:0] ALU_SRL    = 4'b1000;
  localparam logic [3:0] ALU_SRA    = 4'b1001;
  localparam logic [3:0] ALU_SLTU   = 4'b1011;
  localparam logic [3:0] ALU_SLT    = 4'b1100;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_U,
    IMM_SHAMT,
    IMM_LINK
  } imm_type_e;

  typedef enum logic [1:0] {
    OP1_RS1,
    OP1_PC,
    OP1_ZERO
  } op1_sel_e;

  typedef enum logic [1:0] {
    OP2_RS2,
    OP2_IMM,
    OP2_ZERO
  } op2_sel_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  aluSel;
    logic        sign;
    logic        shift;
    logic [4:0]  rd;
    logic        rdWe;
    logic        isBranch;
    logic        illegal;
  } issue_pkt_t;

  // Shift immediates carry only the 5-bit shamt so SRAI's funct7 bits never reach the ALU.
  function automatic logic [31:0] genImm(imm_type_e immType, logic [31:0] instr);
    logic [31:0] imm;
    case (immType)
      IMM_I:     imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_U:     imm = {instr[31:12], 12'b0};
      IMM_SHAMT: imm = {27'b0, instr[24:20]};
      IMM_LINK:  imm = 32'd4;
      default:   imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: upstream instruction handshake plus the registered ALU operand bundle.
// The performance counter outputs exist only when ALU_ISSUE_PERF_EN is defined.
interface alu_issue_stage_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready_up;
  logic [31:0]     i_instr;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic            i_flush;
  logic            i_ready_dn;
  logic            o_valid;
  logic [XLEN-1:0] o_pc;
  logic [XLEN-1:0] o_i_1;
  logic [XLEN-1:0] o_i_2;
  logic [3:0]      o_aluSel;
  logic            o_sign;
  logic            o_shift;
  logic [4:0]      o_rd;
  logic            o_rd_we;
  logic            o_is_branch;
  logic            o_illegal;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0]     o_issue_cnt;
  logic [31:0]     o_stall_cnt;
`endif

  modport slave (
    input  i_valid, i_instr, i_pc, i_rs1, i_rs2, i_flush, i_ready_dn,
`ifdef ALU_ISSUE_PERF_EN
    output o_issue_cnt, o_stall_cnt,
`endif
    output o_ready_up, o_valid, o_pc, o_i_1, o_i_2, o_aluSel, o_sign, o_shift,
           o_rd, o_rd_we, o_is_branch, o_illegal
  );

  modport master (
    output i_valid, i_instr, i_pc, i_rs1, i_rs2, i_flush, i_ready_dn,
`ifdef ALU_ISSUE_PERF_EN
    input  o_issue_cnt, o_stall_cnt,
`endif
    input  o_ready_up, o_valid, o_pc, o_i_1, o_i_2, o_aluSel, o_sign, o_shift,
           o_rd, o_rd_we, o_is_branch, o_illegal
  );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I decode: instruction word to ALU control, operand selects and immediate.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [3:0]  aluSel_o,
  output logic        sign_o,
  output logic        shift_o,
  output op1_sel_e    op1Sel_o,
  output op2_sel_e    op2Sel_o,
  output logic [31:0] imm_o,
  output logic        rdWe_o,
  output logic        isBranch_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  imm_type_e  immType;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign f7b5   = instr_i[30];

  always_comb begin
    aluSel_o   = ALU_ADD;
    sign_o     = 1'b0;
    shift_o    = 1'b0;
    op1Sel_o   = OP1_ZERO;
    op2Sel_o   = OP2_ZERO;
    immType    = IMM_NONE;
    rdWe_o     = 1'b0;
    isBranch_o = 1'b0;
    illegal_o  = 1'b0;

    case (opcode)
      // Register and immediate ALU ops share one funct3 table; only OP has SUB.
      OPC_OP, OPC_OPIMM: begin
        op1Sel_o = OP1_RS1;
        op2Sel_o = (opcode == OPC_OP) ? OP2_RS2 : OP2_IMM;
        immType  = IMM_I;
        rdWe_o   = 1'b1;
        case (funct3)
          3'b000: aluSel_o = (opcode == OPC_OP && f7b5) ? ALU_SUB : ALU_ADD;
          3'b001: begin
            aluSel_o = ALU_SLL;
            shift_o  = 1'b1;
            immType  = IMM_SHAMT;
          end
          3'b010: begin
            aluSel_o = ALU_SLT;
            sign_o   = 1'b1;
          end
          3'b011: aluSel_o = ALU_SLTU;
          3'b100: aluSel_o = ALU_XOR;
          3'b101: begin
            shift_o  = 1'b1;
            immType  = IMM_SHAMT;
            aluSel_o = f7b5 ? ALU_SRA : ALU_SRL;
            sign_o   = f7b5;
          end
          3'b110: aluSel_o = ALU_OR;
          default: aluSel_o = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        aluSel_o = ALU_PASS_B;
        op2Sel_o = OP2_IMM;
        immType  = IMM_U;
        rdWe_o   = 1'b1;
      end
      OPC_AUIPC: begin
        op1Sel_o = OP1_PC;
        op2Sel_o = OP2_IMM;
        immType  = IMM_U;
        rdWe_o   = 1'b1;
      end
      OPC_LOAD: begin
        op1Sel_o = OP1_RS1;
        op2Sel_o = OP2_IMM;
        immType  = IMM_I;
        rdWe_o   = 1'b1;
      end
      OPC_STORE: begin
        op1Sel_o = OP1_RS1;
        op2Sel_o = OP2_IMM;
        immType  = IMM_S;
      end
      OPC_JAL, OPC_JALR: begin
        op1Sel_o = OP1_PC;
        op2Sel_o = OP2_IMM;
        immType  = IMM_LINK;
        rdWe_o   = 1'b1;
      end
      OPC_BRANCH: begin
        op1Sel_o   = OP1_RS1;
        op2Sel_o   = OP2_RS2;
        isBranch_o = 1'b1;
        case (funct3[2:1])
          2'b10: begin
            aluSel_o = ALU_SLT;
            sign_o   = 1'b1;
          end
          2'b11: aluSel_o = ALU_SLTU;
          default: aluSel_o = ALU_SUB;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

  assign imm_o = genImm(immType, instr_i);

endmodule

// File: rtl/alu_issue_stage.sv
// Registered decode/issue stage feeding the ALU, with valid/ready stall and flush.
// Define ALU_ISSUE_PERF_EN to add the issue and stall counters.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
  input logic             clk,
  input logic             rst,
  alu_issue_stage_if.slave bus
);

  logic        validQ, validD;
  issue_pkt_t  pktQ, pktD, pktIn;
  logic        readyUp, accept;

  logic [3:0]  decAluSel;
  logic        decSign, decShift, decRdWe, decIsBranch, decIllegal;
  op1_sel_e    decOp1Sel;
  op2_sel_e    decOp2Sel;
  logic [31:0] decImm;
  logic [XLEN-1:0] op1, op2;
  logic [4:0]  rdField;

  alu_ctrl_decode uDecode (
    .instr_i    (bus.i_instr),
    .aluSel_o   (decAluSel),
    .sign_o     (decSign),
    .shift_o    (decShift),
    .op1Sel_o   (decOp1Sel),
    .op2Sel_o   (decOp2Sel),
    .imm_o      (decImm),
    .rdWe_o     (decRdWe),
    .isBranch_o (decIsBranch),
    .illegal_o  (decIllegal)
  );

  assign readyUp = ~validQ | bus.i_ready_dn;
  assign accept  = bus.i_valid & readyUp & ~bus.i_flush;
  assign rdField = bus.i_instr[11:7];

  always_comb begin
    op1 = '0;
    op2 = '0;
    case (decOp1Sel)
      OP1_RS1: op1 = bus.i_rs1;
      OP1_PC:  op1 = bus.i_pc;
      default: op1 = '0;
    endcase
    case (decOp2Sel)
      OP2_RS2: op2 = bus.i_rs2;
      OP2_IMM: op2 = decImm;
      default: op2 = '0;
    endcase
  end

  // Writes to x0 are architecturally discarded, so never request writeback for them.
  always_comb begin
    pktIn          = '0;
    pktIn.pc       = bus.i_pc;
    pktIn.op1      = op1;
    pktIn.op2      = op2;
    pktIn.aluSel   = decAluSel;
    pktIn.sign     = decSign;
    pktIn.shift    = decShift;
    pktIn.rd       = rdField;
    pktIn.rdWe     = decRdWe & (rdField != 5'd0);
    pktIn.isBranch = decIsBranch;
    pktIn.illegal  = decIllegal;
  end

  // Hold while stalled, reload on accept, and let flush kill both held and incoming work.
  always_comb begin
    validD = validQ & ~bus.i_ready_dn;
    pktD   = pktQ;
    if (accept) begin
      validD = 1'b1;
      pktD   = pktIn;
    end
    if (bus.i_flush) begin
      validD = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      validQ      <= 1'b0;
      pktQ        <= '0;
      pktQ.aluSel <= ALU_ADD;
    end else begin
      validQ <= validD;
      pktQ   <= pktD;
    end
  end

  assign bus.o_ready_up  = readyUp;
  assign bus.o_valid     = validQ;
  assign bus.o_pc        = validQ ? pktQ.pc : RESET_PC_TAG;
  assign bus.o_i_1       = pktQ.op1;
  assign bus.o_i_2       = pktQ.op2;
  assign bus.o_aluSel    = pktQ.aluSel;
  assign bus.o_sign      = pktQ.sign;
  assign bus.o_shift     = pktQ.shift;
  assign bus.o_rd        = pktQ.rd;
  assign bus.o_rd_we     = pktQ.rdWe;
  assign bus.o_is_branch = pktQ.isBranch;
  assign bus.o_illegal   = pktQ.illegal;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] issueCntQ, issueCntD, stallCntQ, stallCntD;

  assign issueCntD = issueCntQ + {31'b0, accept};
  assign stallCntD = stallCntQ + {31'b0, validQ & ~bus.i_ready_dn};

  always_ff @(posedge clk) begin
    if (rst) begin
      issueCntQ <= '0;
      stallCntQ <= '0;
    end else begin
      issueCntQ <= issueCntD;
      stallCntQ <= stallCntD;
    end
  end

  assign bus.o_issue_cnt = issueCntQ;
  assign bus.o_stall_cnt = stallCntQ;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a queue scoreboard of expected issue packets.
// Counter checks are compiled in when ALU_ISSUE_PERF_EN is defined.
module tb_alu_issue_stage;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] i1;
    logic [31:0] i2;
    logic [3:0]  sel;
    logic        sign;
    logic        shift;
    logic [4:0]  rd;
    logic        rdCare;
    logic        we;
    logic        br;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sbQ[$];
  exp_t none;
  int   assertCount = 0;
  int   failCount = 0;
  int   expIssue = 0;
  int   expStall = 0;

  always #5 clk = ~clk;

  alu_issue_stage_if #(.XLEN(32)) bus ();

  alu_issue_stage #(
    .XLEN         (32),
    .RESET_PC_TAG (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Single comparison point: every check in the bench goes through this assertion.
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, i1, i2, input logic [3:0] sel,
                              input logic sign, shift, input logic [4:0] rd,
                              input logic rdCare, we, br, ill);
    exp_t e;
    e.pc = pc; e.i1 = i1; e.i2 = i2; e.sel = sel; e.sign = sign; e.shift = shift;
    e.rd = rd; e.rdCare = rdCare; e.we = we; e.br = br; e.ill = ill;
    return e;
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] instr, pc, rs1, rs2,
                               input logic rdy, input logic fl);
    bus.i_valid    = v;
    bus.i_instr    = instr;
    bus.i_pc       = pc;
    bus.i_rs1      = rs1;
    bus.i_rs2      = rs2;
    bus.i_ready_dn = rdy;
    bus.i_flush    = fl;
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".valid"}, 32'(bus.o_valid), 32'(sbQ.size() != 0));
    if (sbQ.size() != 0) begin
      checkVal({tag, ".pc"}, bus.o_pc, sbQ[0].pc);
      checkVal({tag, ".i_1"}, bus.o_i_1, sbQ[0].i1);
      checkVal({tag, ".i_2"}, bus.o_i_2, sbQ[0].i2);
      checkVal({tag, ".aluSel"}, 32'(bus.o_aluSel), 32'(sbQ[0].sel));
      checkVal({tag, ".sign"}, 32'(bus.o_sign), 32'(sbQ[0].sign));
      checkVal({tag, ".shift"}, 32'(bus.o_shift), 32'(sbQ[0].shift));
      checkVal({tag, ".rd_we"}, 32'(bus.o_rd_we), 32'(sbQ[0].we));
      checkVal({tag, ".is_branch"}, 32'(bus.o_is_branch), 32'(sbQ[0].br));
      checkVal({tag, ".illegal"}, 32'(bus.o_illegal), 32'(sbQ[0].ill));
      if (sbQ[0].rdCare) checkVal({tag, ".rd"}, 32'(bus.o_rd), 32'(sbQ[0].rd));
    end else begin
      checkVal({tag, ".pc_tag"}, bus.o_pc, 32'h0000_0000);
    end
`ifdef ALU_ISSUE_PERF_EN
    checkVal({tag, ".issue_cnt"}, bus.o_issue_cnt, 32'(expIssue));
    checkVal({tag, ".stall_cnt"}, bus.o_stall_cnt, 32'(expStall));
`endif
  endtask

  // One clock: check ready before the edge, advance the scoreboard, check outputs after.
  task automatic cycle(input exp_t e, input string tag);
    logic modelReady, modelAccept;
    @(negedge clk);
    modelReady  = (sbQ.size() == 0) | bus.i_ready_dn;
    modelAccept = bus.i_valid & modelReady & ~bus.i_flush;
    checkVal({tag, ".ready_up"}, 32'(bus.o_ready_up), 32'(modelReady));
    if (rst) begin
      sbQ.delete();
      expIssue = 0;
      expStall = 0;
    end else begin
      if (sbQ.size() != 0 && !bus.i_ready_dn) expStall++;
      if (bus.i_flush) begin
        sbQ.delete();
      end else begin
        if (sbQ.size() != 0 && bus.i_ready_dn) void'(sbQ.pop_front());
        if (modelAccept) begin
          sbQ.push_back(e);
          expIssue++;
        end
      end
    end
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic checkReset(input string tag);
    checkVal({tag, ".valid"}, 32'(bus.o_valid), 32'd0);
    checkVal({tag, ".ready_up"}, 32'(bus.o_ready_up), 32'd1);
    checkVal({tag, ".pc"}, bus.o_pc, 32'h0);
    checkVal({tag, ".i_1"}, bus.o_i_1, 32'h0);
    checkVal({tag, ".i_2"}, bus.o_i_2, 32'h0);
    checkVal({tag, ".aluSel"}, 32'(bus.o_aluSel), 32'(4'b0011));
    checkVal({tag, ".sign"}, 32'(bus.o_sign), 32'd0);
    checkVal({tag, ".shift"}, 32'(bus.o_shift), 32'd0);
    checkVal({tag, ".rd"}, 32'(bus.o_rd), 32'd0);
    checkVal({tag, ".rd_we"}, 32'(bus.o_rd_we), 32'd0);
    checkVal({tag, ".is_branch"}, 32'(bus.o_is_branch), 32'd0);
    checkVal({tag, ".illegal"}, 32'(bus.o_illegal), 32'd0);
`ifdef ALU_ISSUE_PERF_EN
    checkVal({tag, ".issue_cnt"}, bus.o_issue_cnt, 32'd0);
    checkVal({tag, ".stall_cnt"}, bus.o_stall_cnt, 32'd0);
`endif
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    none = mk(32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkReset("reset");
    rst = 1'b0;

    $display("[TB] ALU ops, back-to-back");
    applyStimulus(1'b1, 32'h0020_81B3, 32'h100, 32'd5, 32'd7, 1'b1, 1'b0);
    cycle(mk(32'h100, 32'd5, 32'd7, ALU_ADD, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0), "add");
    applyStimulus(1'b1, 32'h4020_82B3, 32'h104, 32'd10, 32'd3, 1'b1, 1'b0);
    cycle(mk(32'h104, 32'd10, 32'd3, ALU_SUB, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0), "sub");
    applyStimulus(1'b1, 32'h4030_D213, 32'h108, 32'h8000_0000, 32'h0, 1'b1, 1'b0);
    cycle(mk(32'h108, 32'h8000_0000, 32'd3, ALU_SRA, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0), "srai");
    applyStimulus(1'b1, 32'hFFF0_A313, 32'h10C, 32'd1, 32'h0, 1'b1, 1'b0);
    cycle(mk(32'h10C, 32'd1, 32'hFFFF_FFFF, ALU_SLT, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0), "slti");
    applyStimulus(1'b1, 32'h0020_9533, 32'h110, 32'h0000_00F0, 32'd4, 1'b1, 1'b0);
    cycle(mk(32'h110, 32'h0000_00F0, 32'd4, ALU_SLL, 1'b0, 1'b1, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0), "sll");

    $display("[TB] back-pressure on LUI");
    applyStimulus(1'b1, 32'h1234_53B7, 32'h114, 32'h0000_AAAA, 32'h0000_BBBB, 1'b1, 1'b0);
    cycle(mk(32'h114, 32'h0, 32'h1234_5000, ALU_PASS_B, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0), "lui");
    applyStimulus(1'b1, 32'h0000_1417, 32'h200, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) cycle(none, "stall");
    applyStimulus(1'b1, 32'h0000_1417, 32'h200, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(mk(32'h200, 32'h200, 32'h0000_1000, ALU_ADD, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0), "auipc");

    $display("[TB] flush mid-stall");
    applyStimulus(1'b1, 32'h0000_00EF, 32'h300, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(none, "flush");

    $display("[TB] jump, memory, branch");
    applyStimulus(1'b1, 32'h0000_00EF, 32'h300, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(mk(32'h300, 32'h300, 32'd4, ALU_ADD, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0), "jal");
    applyStimulus(1'b1, 32'h0020_A423, 32'h304, 32'h0000_1000, 32'h77, 1'b1, 1'b0);
    cycle(mk(32'h304, 32'h0000_1000, 32'd8, ALU_ADD, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), "sw");
    applyStimulus(1'b1, 32'hFFC0_A483, 32'h308, 32'h0000_2000, 32'h0, 1'b1, 1'b0);
    cycle(mk(32'h308, 32'h0000_2000, 32'hFFFF_FFFC, ALU_ADD, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0), "lw");
    applyStimulus(1'b1, 32'h0020_E063, 32'h30C, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    cycle(mk(32'h30C, 32'd1, 32'hFFFF_FFFF, ALU_SLTU, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0), "bltu");
    applyStimulus(1'b1, 32'h0020_8063, 32'h310, 32'd7, 32'd7, 1'b1, 1'b0);
    cycle(mk(32'h310, 32'd7, 32'd7, ALU_SUB, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0), "beq");

    $display("[TB] illegal opcode and rd=x0");
    applyStimulus(1'b1, 32'h0000_007F, 32'h314, 32'h0000_1234, 32'h0000_5678, 1'b1, 1'b0);
    cycle(mk(32'h314, 32'h0, 32'h0, ALU_ADD, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1), "illegal");
    applyStimulus(1'b1, 32'h0010_0013, 32'h318, 32'h0000_0055, 32'h0, 1'b1, 1'b0);
    cycle(mk(32'h318, 32'h0000_0055, 32'd1, ALU_ADD, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), "addi_x0");
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(none, "drain");

    $display("[TB] reset mid-stall");
    applyStimulus(1'b1, 32'h0020_81B3, 32'h400, 32'd1, 32'd2, 1'b0, 1'b0);
    cycle(mk(32'h400, 32'd1, 32'd2, ALU_ADD, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0), "pre_rst");
    rst = 1'b1;
    cycle(none, "rst_stall");
    checkReset("reset2");
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(none, "idle");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer side of the execute-stage ALU interface: registered decode/issue stage.
- Takes a fetched RV32I instruction with register-file operands and PC.
- Emits the ALU operand pair, aluSel, sign and shift controls, plus writeback info, one cycle later.
- Sits between register read and the ALU; a valid/ready handshake supports pipeline stall, and a flush input supports branch redirect.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC_TAG, 32'h0000_0000, value driven on o_pc while o_valid=0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_valid  in  1  upstream instruction valid
- o_ready_up  out  1  stage can accept (= !o_valid | i_ready_dn)
- i_instr  in  32  instruction word
- i_pc  in  32  instruction PC
- i_rs1  in  32  rs1 register data
- i_rs2  in  32  rs2 register data
- i_flush  in  1  kill the held and incoming instruction
- i_ready_dn  in  1  ALU/EX stage accepts
- o_valid  out  1  outputs valid
- o_pc  out  32  registered PC
- o_i_1  out  32  ALU operand 1
- o_i_2  out  32  ALU operand 2
- o_aluSel  out  4  ALU operation code
- o_sign  out  1  signed compare / arithmetic shift
- o_shift  out  1  shift operation
- o_rd  out  5  destination register
- o_rd_we  out  1  writeback enable
- o_is_branch  out  1  conditional branch (uses ALU compare result)
- o_illegal  out  1  unsupported opcode

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: all outputs 0, except o_pc = RESET_PC_TAG and o_aluSel = ADD (0011).
- Latency: exactly 1 cycle from an accepted input to o_valid.
- Accept condition: i_valid & o_ready_up & !i_flush.
  - On accept: load all output registers and set o_valid.
- Hold: if o_valid & !i_ready_dn, all outputs are held stable and o_ready_up = 0.
- Drain: if o_valid & i_ready_dn and no accept, clear o_valid next cycle. Payload registers may keep stale values.
- Back-to-back: accept and drain in the same cycle reloads the registers; o_valid stays 1 (full throughput).
- Flush dominates: next cycle o_valid = 0, regardless of i_valid or i_ready_dn. Flush and reset are both legal mid-stall.
- Decode (opcode, then funct3/funct7):
  - OP: i_1 = rs1, i_2 = rs2.
    - ADD, SUB (f7[5]), AND, OR, XOR.
    - SLL: shift=1.
    - SRL: shift=1.
    - SRA (f7[5]): shift=1, sign=1.
    - SLT: sign=1.
    - SLTU.
    - rd_we = 1.
  - OP-IMM: as OP with i_2 = sign-extended I-imm; f7[5] distinguishes only SRAI; no SUB.
  - LUI: PASS_B with i_2 = U-imm.
  - AUIPC: ADD, i_1 = pc, i_2 = U-imm.
  - LOAD and STORE: ADD with I-imm or S-imm. STORE has rd_we = 0.
  - JAL/JALR: ADD, i_1 = pc, i_2 = 4 (link value), rd_we = 1.
  - BRANCH: rd_we = 0, is_branch = 1.
    - BEQ/BNE: SUB.
    - BLT/BGE: SLT with sign=1.
    - BLTU/BGEU: SLTU.
  - Any other opcode: illegal = 1, rd_we = 0, aluSel = ADD, operands 0.
- rd = 0: o_rd_we forced to 0.
- aluSel codes: AND 0000, OR 0001, XOR 0010, ADD 0011, SUB 0100, PASS_B 0110, SLL 0111, SRL 1000, SRA 1001, SLTU 1011, SLT 1100. Code 1010 is never emitted.

Optional Feature:
- Macro: ALU_ISSUE_PERF_EN.
- Defined: adds outputs o_issue_cnt[31:0] and o_stall_cnt[31:0].
  - o_issue_cnt increments on each accepted non-flushed instruction.
  - o_stall_cnt increments each cycle o_valid & !i_ready_dn.
  - Both are cleared by rst and wrap at 2^32.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - ALU_AND ... ALU_SLT 4-bit constants.
  - RV32 opcode constants (OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_BRANCH).
  - Immediate-type enum.
- Sub-module alu_ctrl_decode: purely combinational; instruction to aluSel/sign/shift/operand-select/imm.
- Top holds the handshake and pipeline register.

Test Plan:
- ADD x3,x1,x2 with rs1=5, rs2=7, i_ready_dn=1 -> next cycle o_valid=1, i_1=5, i_2=7, aluSel=0011, rd=3, rd_we=1.
- SRAI x4,x1,3 (instr 0x4030D213), rs1=0x8000_0000 -> aluSel=1001, shift=1, sign=1, i_2=3.
- Back-pressure: i_ready_dn=0 for 3 cycles after a valid LUI 0x12345 -> outputs stable with i_2=0x12345000, o_ready_up=0; release -> next instruction issues the following cycle.
- i_flush asserted with i_valid=1 and o_valid=1 -> o_valid=0 next cycle, and no counter increment when PERF is enabled.
- BLTU (funct3=110) with rs1=1, rs2=0xFFFF_FFFF -> aluSel=1011, sign=0, is_branch=1, rd_we=0.
- Opcode 0x7F; then ADDI x0,x0,1 -> first gives illegal=1, rd_we=0; second gives rd_we=0 because rd=0.
